// File: rtl/zbnt_axi_pkg.sv
// Shared AXI4-Lite definitions for the zbnt PCIe bridge blocks.
//   axil_state_t     : transaction FSM state encoding used by pcie_axil_master
//   AXI_RESP_OKAY    : AXI response code for a normal completion
//   AXI_RESP_SLVERR  : AXI response code for a slave error (also used for timeouts)
package zbnt_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE      = 3'd1,
    ST_WRITE_RESP = 3'd2,
    ST_READ       = 3'd3,
    ST_READ_DATA  = 3'd4,
    ST_DRAIN      = 3'd5
  } axil_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/pcie_axil_master.sv
// Single-outstanding AXI4-Lite master driven by a simple command/response port.
// A command is taken when cmd_valid and cmd_ready are both high; the matching
// AXI4-Lite write (aw+w, then b) or read (ar, then r) is issued, and exactly one
// one-cycle rsp_valid pulse reports the result. A slave that does not answer
// within TIMEOUT_CYCLES produces a SLVERR/timeout response; the late answer is
// then absorbed in DRAIN without a second response.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   cmd_*                  : command in (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                  : response out (valid pulse, write, rdata, resp, timeout)
//   m_axi_pcie_*           : AXI4-Lite master channels aw, w, b, ar, r
module pcie_axil_master
  import zbnt_axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 22,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   m_axi_pcie_awaddr,
  output logic                    m_axi_pcie_awvalid,
  input  logic                    m_axi_pcie_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_pcie_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_pcie_wstrb,
  output logic                    m_axi_pcie_wvalid,
  input  logic                    m_axi_pcie_wready,
  input  logic [1:0]              m_axi_pcie_bresp,
  input  logic                    m_axi_pcie_bvalid,
  output logic                    m_axi_pcie_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_pcie_araddr,
  output logic                    m_axi_pcie_arvalid,
  input  logic                    m_axi_pcie_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_pcie_rdata,
  input  logic [1:0]              m_axi_pcie_rresp,
  input  logic                    m_axi_pcie_rvalid,
  output logic                    m_axi_pcie_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  axil_state_t            state_reg;
  logic [CNT_WIDTH-1:0]   cnt_reg;
  logic [CNT_WIDTH-1:0]   cnt_next;
  logic                   is_write_reg;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [DATA_WIDTH-1:0]  wdata_reg;
  logic [STRB_WIDTH-1:0]  wstrb_reg;
  logic                   awvalid_reg;
  logic                   wvalid_reg;
  logic                   arvalid_reg;
  logic                   rsp_valid_reg;
  logic                   rsp_write_reg;
  logic [DATA_WIDTH-1:0]  rsp_rdata_reg;
  logic [1:0]             rsp_resp_reg;
  logic                   rsp_timeout_reg;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic timeout_hit;

  assign aw_hs = awvalid_reg & m_axi_pcie_awready;
  assign w_hs  = wvalid_reg  & m_axi_pcie_wready;
  assign ar_hs = arvalid_reg & m_axi_pcie_arready;
  assign b_hs  = m_axi_pcie_bvalid & m_axi_pcie_bready;
  assign r_hs  = m_axi_pcie_rvalid & m_axi_pcie_rready;

  // The counter reaches its last value on this edge; a response handshaking
  // on the same edge takes priority in the response states below.
  assign cnt_next    = cnt_reg + 1'b1;
  assign timeout_hit = (cnt_next == CNT_LAST);

  assign cmd_ready          = (state_reg == ST_IDLE);
  assign m_axi_pcie_bready  = (state_reg == ST_WRITE_RESP) || (state_reg == ST_DRAIN);
  assign m_axi_pcie_rready  = (state_reg == ST_READ_DATA)  || (state_reg == ST_DRAIN);
  assign m_axi_pcie_awaddr  = addr_reg;
  assign m_axi_pcie_araddr  = addr_reg;
  assign m_axi_pcie_wdata   = wdata_reg;
  assign m_axi_pcie_wstrb   = wstrb_reg;
  assign m_axi_pcie_awvalid = awvalid_reg;
  assign m_axi_pcie_wvalid  = wvalid_reg;
  assign m_axi_pcie_arvalid = arvalid_reg;
  assign rsp_valid          = rsp_valid_reg;
  assign rsp_write          = rsp_write_reg;
  assign rsp_rdata          = rsp_rdata_reg;
  assign rsp_resp           = rsp_resp_reg;
  assign rsp_timeout        = rsp_timeout_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      is_write_reg    <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      wstrb_reg       <= '0;
      awvalid_reg     <= 1'b0;
      wvalid_reg      <= 1'b0;
      arvalid_reg     <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_write_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_resp_reg    <= AXI_RESP_OKAY;
      rsp_timeout_reg <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;

      // Each request valid retires on its own handshake, in any state; this
      // also lets DRAIN finish off requests that were still pending.
      if (aw_hs) awvalid_reg <= 1'b0;
      if (w_hs)  wvalid_reg  <= 1'b0;
      if (ar_hs) arvalid_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            cnt_reg      <= '0;
            is_write_reg <= cmd_write;
            addr_reg     <= cmd_addr;
            wdata_reg    <= cmd_wdata;
            wstrb_reg    <= cmd_wstrb;
            awvalid_reg  <= cmd_write;
            wvalid_reg   <= cmd_write;
            arvalid_reg  <= ~cmd_write;
            state_reg    <= cmd_write ? ST_WRITE : ST_READ;
          end
        end

        ST_WRITE: begin
          cnt_reg <= cnt_next;
          if (timeout_hit) begin
            rsp_valid_reg   <= 1'b1;
            rsp_write_reg   <= 1'b1;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= AXI_RESP_SLVERR;
            rsp_timeout_reg <= 1'b1;
            state_reg       <= ST_DRAIN;
          end else if ((!awvalid_reg || aw_hs) && (!wvalid_reg || w_hs)) begin
            state_reg <= ST_WRITE_RESP;
          end
        end

        ST_WRITE_RESP: begin
          cnt_reg <= cnt_next;
          if (b_hs) begin
            rsp_valid_reg   <= 1'b1;
            rsp_write_reg   <= 1'b1;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= m_axi_pcie_bresp;
            rsp_timeout_reg <= 1'b0;
            state_reg       <= ST_IDLE;
          end else if (timeout_hit) begin
            rsp_valid_reg   <= 1'b1;
            rsp_write_reg   <= 1'b1;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= AXI_RESP_SLVERR;
            rsp_timeout_reg <= 1'b1;
            state_reg       <= ST_DRAIN;
          end
        end

        ST_READ: begin
          cnt_reg <= cnt_next;
          if (timeout_hit) begin
            rsp_valid_reg   <= 1'b1;
            rsp_write_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= AXI_RESP_SLVERR;
            rsp_timeout_reg <= 1'b1;
            state_reg       <= ST_DRAIN;
          end else if (ar_hs) begin
            state_reg <= ST_READ_DATA;
          end
        end

        ST_READ_DATA: begin
          cnt_reg <= cnt_next;
          if (r_hs) begin
            rsp_valid_reg   <= 1'b1;
            rsp_write_reg   <= 1'b0;
            rsp_rdata_reg   <= m_axi_pcie_rdata;
            rsp_resp_reg    <= m_axi_pcie_rresp;
            rsp_timeout_reg <= 1'b0;
            state_reg       <= ST_IDLE;
          end else if (timeout_hit) begin
            rsp_valid_reg   <= 1'b1;
            rsp_write_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= AXI_RESP_SLVERR;
            rsp_timeout_reg <= 1'b1;
            state_reg       <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          // Only the channel belonging to the abandoned transaction ends it;
          // the late response is swallowed without reporting.
          if (is_write_reg ? b_hs : r_hs) begin
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_axil_master.sv
// Directed bench for pcie_axil_master with a small delay-programmable AXI4-Lite
// slave. Edge indices are counted by a monitor; latencies are measured from the
// command-accept edge to the edge that samples rsp_valid.
module tb_pcie_axil_master;
  import zbnt_axi_pkg::*;

  localparam int AW = 22;
  localparam int DW = 64;
  localparam int TO = 16;

  logic          clk;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [7:0]    cmd_wstrb;
  logic          rsp_valid, rsp_write, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [7:0]    wstrb;
  logic [1:0]    bresp, rresp;

  pcie_axil_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_pcie_awaddr(awaddr), .m_axi_pcie_awvalid(awvalid), .m_axi_pcie_awready(awready),
    .m_axi_pcie_wdata(wdata), .m_axi_pcie_wstrb(wstrb), .m_axi_pcie_wvalid(wvalid),
    .m_axi_pcie_wready(wready),
    .m_axi_pcie_bresp(bresp), .m_axi_pcie_bvalid(bvalid), .m_axi_pcie_bready(bready),
    .m_axi_pcie_araddr(araddr), .m_axi_pcie_arvalid(arvalid), .m_axi_pcie_arready(arready),
    .m_axi_pcie_rdata(rdata), .m_axi_pcie_rresp(rresp), .m_axi_pcie_rvalid(rvalid),
    .m_axi_pcie_rready(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave configuration (written by the main sequence only).
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [DW-1:0] r_data_cfg = '0;
  logic [1:0]  r_resp_cfg = 2'b00;
  logic [1:0]  b_resp_cfg = 2'b00;

  // Monitor-owned counters.
  int cyc = 0, acc_cyc = 0;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_rsp = 0;

  // Checker counters.
  int n_checks = 0, n_fail = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (awvalid && awready) n_aw++;
        if (wvalid && wready)   n_w++;
        if (bvalid && bready)   n_b++;
        if (arvalid && arready) n_ar++;
        if (rvalid && rready)   n_r++;
        if (rsp_valid)          n_rsp++;
      end
    end
  end

  // Slave driver: readies/valids change only on the falling edge.
  initial begin
    int aw_age, w_age, ar_age, b_age, r_age, b_drop, r_drop, aw_w_min;
    aw_age = 0; w_age = 0; ar_age = 0; b_age = 0; r_age = 0; b_drop = 0; r_drop = 0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      @(negedge clk);
      aw_w_min = (n_aw < n_w) ? n_aw : n_w;
      if (rst) begin
        aw_age = 0; w_age = 0; ar_age = 0; b_age = 0; r_age = 0;
        b_drop = aw_w_min - n_b;
        r_drop = n_ar - n_r;
        awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
      end else begin
        aw_age = awvalid ? aw_age + 1 : 0;
        w_age  = wvalid  ? w_age + 1  : 0;
        ar_age = arvalid ? ar_age + 1 : 0;
        awready = awvalid && (aw_age > aw_delay);
        wready  = wvalid  && (w_age > w_delay);
        arready = arvalid && (ar_age > ar_delay);
        if (n_b + b_drop < aw_w_min) begin
          b_age++;
          bvalid = (b_age > b_delay);
          bresp  = b_resp_cfg;
        end else begin
          b_age = 0;
          bvalid = 1'b0;
        end
        if (n_r + r_drop < n_ar) begin
          r_age++;
          rvalid = (r_age > r_delay);
          rdata  = r_data_cfg;
          rresp  = r_resp_cfg;
        end else begin
          r_age = 0;
          rvalid = 1'b0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge right after acceptance.
  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [7:0] strb);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    check_eq("cmd_accept", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Returns on the falling edge where rsp_valid is high (or after max edges).
  task automatic wait_rsp(input int max, output int lat);
    logic seen;
    seen = 1'b0;
    lat = -1;
    for (int i = 0; i < max; i++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        lat = cyc + 1 - acc_cyc;
        break;
      end
      @(negedge clk);
    end
    check_eq("rsp_seen", 64'(seen), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, s_aw, s_w, s_b, s_ar, s_r, s_rsp, got_r;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("rst_awvalid",   64'(awvalid),   64'd0);
    check_eq("rst_wvalid",    64'(wvalid),    64'd0);
    check_eq("rst_arvalid",   64'(arvalid),   64'd0);
    check_eq("rst_bready",    64'(bready),    64'd0);
    check_eq("rst_rready",    64'(rready),    64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait write.
    s_aw = n_aw; s_w = n_w; s_b = n_b; s_rsp = n_rsp;
    send_cmd(1'b1, 22'h000100, 64'h1122334455667788, 8'hFF);
    check_eq("w1_awvalid", 64'(awvalid), 64'd1);
    check_eq("w1_wvalid",  64'(wvalid),  64'd1);
    check_eq("w1_awaddr",  64'(awaddr),  64'h100);
    check_eq("w1_wdata",   wdata,        64'h1122334455667788);
    check_eq("w1_wstrb",   64'(wstrb),   64'hFF);
    wait_rsp(20, lat);
    check_eq("w1_latency",   64'(lat),         64'd3);
    check_eq("w1_resp",      64'(rsp_resp),    64'd0);
    check_eq("w1_write",     64'(rsp_write),   64'd1);
    check_eq("w1_rdata",     rsp_rdata,        64'd0);
    check_eq("w1_timeout",   64'(rsp_timeout), 64'd0);
    check_eq("w1_cmd_ready", 64'(cmd_ready),   64'd1);
    @(negedge clk);
    check_eq("w1_rsp_pulse", 64'(rsp_valid),   64'd0);
    check_eq("w1_n_aw",  64'(n_aw - s_aw),   64'd1);
    check_eq("w1_n_w",   64'(n_w - s_w),     64'd1);
    check_eq("w1_n_b",   64'(n_b - s_b),     64'd1);
    check_eq("w1_n_rsp", 64'(n_rsp - s_rsp), 64'd1);
    $display("txn write addr=0x000100 lat=%0d resp=%0d", lat, rsp_resp);

    // Write with wready lagging awready by three cycles.
    w_delay = 3;
    s_aw = n_aw; s_w = n_w; s_b = n_b; s_rsp = n_rsp;
    send_cmd(1'b1, 22'h000208, 64'hA5A5A5A55A5A5A5A, 8'h0F);
    @(negedge clk);
    check_eq("w2_awvalid_dropped", 64'(awvalid), 64'd0);
    check_eq("w2_wvalid_held",     64'(wvalid),  64'd1);
    check_eq("w2_wdata_stable",    wdata,        64'hA5A5A5A55A5A5A5A);
    check_eq("w2_wstrb_stable",    64'(wstrb),   64'h0F);
    wait_rsp(30, lat);
    check_eq("w2_latency", 64'(lat), 64'd6);
    @(negedge clk);
    check_eq("w2_n_aw",  64'(n_aw - s_aw),   64'd1);
    check_eq("w2_n_w",   64'(n_w - s_w),     64'd1);
    check_eq("w2_n_b",   64'(n_b - s_b),     64'd1);
    check_eq("w2_n_rsp", 64'(n_rsp - s_rsp), 64'd1);
    $display("txn write addr=0x000208 lat=%0d resp=%0d", lat, rsp_resp);
    w_delay = 0;

    // Zero-wait read at the top of the address space, slave returns SLVERR.
    r_data_cfg = 64'hDEADBEEFCAFEF00D; r_resp_cfg = 2'b10;
    s_ar = n_ar; s_r = n_r; s_rsp = n_rsp;
    send_cmd(1'b0, 22'h3FFFF8, 64'd0, 8'h00);
    check_eq("r1_arvalid", 64'(arvalid), 64'd1);
    check_eq("r1_araddr",  64'(araddr),  64'h3FFFF8);
    check_eq("r1_awvalid", 64'(awvalid), 64'd0);
    wait_rsp(20, lat);
    check_eq("r1_latency", 64'(lat),         64'd3);
    check_eq("r1_rdata",   rsp_rdata,        64'hDEADBEEFCAFEF00D);
    check_eq("r1_resp",    64'(rsp_resp),    64'd2);
    check_eq("r1_write",   64'(rsp_write),   64'd0);
    check_eq("r1_timeout", 64'(rsp_timeout), 64'd0);
    @(negedge clk);
    check_eq("r1_n_ar",  64'(n_ar - s_ar),   64'd1);
    check_eq("r1_n_r",   64'(n_r - s_r),     64'd1);
    check_eq("r1_n_rsp", 64'(n_rsp - s_rsp), 64'd1);
    $display("txn read addr=0x3ffff8 lat=%0d rdata=0x%h resp=%0d", lat, rsp_rdata, rsp_resp);

    // Read data arriving on the very edge the timeout would fire: data wins.
    r_delay = 13; r_data_cfg = 64'h0123456789ABCDEF; r_resp_cfg = 2'b00;
    s_rsp = n_rsp;
    send_cmd(1'b0, 22'h000040, 64'd0, 8'h00);
    wait_rsp(40, lat);
    check_eq("r2_latency", 64'(lat),         64'd16);
    check_eq("r2_timeout", 64'(rsp_timeout), 64'd0);
    check_eq("r2_rdata",   rsp_rdata,        64'h0123456789ABCDEF);
    check_eq("r2_resp",    64'(rsp_resp),    64'd0);
    @(negedge clk);
    check_eq("r2_n_rsp", 64'(n_rsp - s_rsp), 64'd1);
    $display("txn read addr=0x000040 lat=%0d timeout=%0d", lat, rsp_timeout);

    // Read whose data is withheld 40 cycles: timeout, then silent drain.
    r_delay = 40; r_data_cfg = 64'hFFFF0000FFFF0000; r_resp_cfg = 2'b00;
    s_r = n_r; s_rsp = n_rsp;
    send_cmd(1'b0, 22'h000080, 64'd0, 8'h00);
    wait_rsp(40, lat);
    check_eq("r3_latency", 64'(lat),         64'd16);
    check_eq("r3_timeout", 64'(rsp_timeout), 64'd1);
    check_eq("r3_resp",    64'(rsp_resp),    64'd2);
    check_eq("r3_rdata",   rsp_rdata,        64'd0);
    @(negedge clk);
    check_eq("r3_drain_cmd_ready", 64'(cmd_ready), 64'd0);
    check_eq("r3_drain_rready",    64'(rready),    64'd1);
    got_r = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (n_r > s_r) begin
        got_r = 1;
        break;
      end
    end
    check_eq("r3_late_r_taken",  64'(got_r),     64'd1);
    check_eq("r3_post_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("r3_post_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (3) @(negedge clk);
    check_eq("r3_n_rsp", 64'(n_rsp - s_rsp), 64'd1);
    $display("txn read addr=0x000080 lat=%0d timeout=%0d (late data drained)", lat, rsp_timeout);
    r_delay = 0;

    // Reset while waiting for the write response.
    b_delay = 5;
    s_b = n_b; s_rsp = n_rsp;
    send_cmd(1'b1, 22'h000300, 64'h0000000011110000, 8'hF0);
    @(negedge clk);
    check_eq("rw_bready_before", 64'(bready), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rw_cmd_ready",  64'(cmd_ready),   64'd1);
    check_eq("rw_awvalid",    64'(awvalid),     64'd0);
    check_eq("rw_wvalid",     64'(wvalid),      64'd0);
    check_eq("rw_arvalid",    64'(arvalid),     64'd0);
    check_eq("rw_bready",     64'(bready),      64'd0);
    check_eq("rw_rready",     64'(rready),      64'd0);
    check_eq("rw_rsp_valid",  64'(rsp_valid),   64'd0);
    check_eq("rw_rsp_resp",   64'(rsp_resp),    64'd0);
    check_eq("rw_rsp_timeout", 64'(rsp_timeout), 64'd0);
    check_eq("rw_rsp_rdata",  rsp_rdata,        64'd0);
    @(negedge clk);
    rst = 1'b0;
    b_delay = 0;
    repeat (10) @(negedge clk);
    check_eq("rw_n_rsp", 64'(n_rsp - s_rsp), 64'd0);
    check_eq("rw_n_b",   64'(n_b - s_b),     64'd0);
    $display("txn write addr=0x000300 abandoned by reset");

    // Recovery read after the reset.
    r_data_cfg = 64'h00000000000055AA; r_resp_cfg = 2'b00;
    send_cmd(1'b0, 22'h000010, 64'd0, 8'h00);
    wait_rsp(20, lat);
    check_eq("r4_latency", 64'(lat),      64'd3);
    check_eq("r4_rdata",   rsp_rdata,     64'h55AA);
    check_eq("r4_resp",    64'(rsp_resp), 64'd0);
    $display("txn read addr=0x000010 lat=%0d rdata=0x%h", lat, rsp_rdata);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_axil_master.md
PCIE_AXIL_MASTER -- requirements
Module: pcie_axil_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 22, AXI4-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, AXI4-Lite data width; strobe width DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, response timeout in clk cycles.
REQ-004 SHALL have ports; one clock, reset synchronous and active-high:
- clk  in  1  sole clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write strobes
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  AXI response code
- rsp_timeout  out  1  response timed out
- m_axi_pcie_aw{addr,valid,ready}, w{data,strb,valid,ready}, b{resp,valid,ready}, ar{addr,valid,ready}, r{data,resp,valid,ready}: AXI4-Lite master, widths per parameters; ready/resp/data from slave are inputs.

Function
REQ-005 SHALL implement states IDLE, WRITE, WRITE_RESP, READ, READ_DATA, DRAIN.
REQ-006 SHALL assert cmd_ready only in IDLE; other states hold it low.
REQ-007 SHALL register addr/data/strb on acceptance and assert awvalid+wvalid (write) or arvalid (read) on the next cycle.
REQ-008 WRITE: SHALL drop awvalid and wvalid independently on their own handshakes; on both complete (same or different cycles) SHALL go to WRITE_RESP.
REQ-009 SHALL never deassert a valid before its handshake; addr/data/strb SHALL stay stable while valid.
REQ-010 SHALL assert bready only in WRITE_RESP and DRAIN, rready only in READ_DATA and DRAIN.
REQ-011 On bvalid&bready or rvalid&rready SHALL pulse rsp_valid the next cycle with captured bresp/rresp and rdata, rsp_timeout=0, then return to IDLE; cmd_ready high that same cycle.
REQ-012 SHALL run a timeout counter, cleared on command acceptance, incrementing every cycle outside IDLE/DRAIN.
REQ-013 On counter reaching TIMEOUT_CYCLES-1 with no response: SHALL pulse rsp_valid with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0, and enter DRAIN.
REQ-014 DRAIN: SHALL keep any un-handshaken aw/w/ar valid asserted, accept and discard the late response, then return to IDLE; no second rsp_valid.
REQ-015 Response arriving on the timeout cycle SHALL win: normal response, no timeout.
REQ-016 Minimum turnaround, zero-wait slave: accept N, valid N+1, response N+2, rsp_valid N+3, next accept N+3.
REQ-017 SHALL be strictly single-outstanding; at most one transaction in flight.

Reset
REQ-018 rst SHALL force IDLE and clear counter; outputs next cycle: cmd_ready=1, all m_axi valids/readies=0, rsp_valid=0, rsp_*=0.
REQ-019 rst mid-transaction SHALL abandon it with no rsp_valid; upstream interconnect is reset jointly.

Structure
REQ-020 State encoding and AXI response codes (OKAY, SLVERR) SHALL live in shared package zbnt_axi_pkg.
REQ-021 SHALL be a single module with no sub-modules; timeout counter width $clog2(TIMEOUT_CYCLES).

Verification
REQ-022 Write 0x000100, data 0x1122334455667788, strb 0xFF, slave zero-wait -> one aw and one w handshake, rsp_valid 3 cycles after accept, rsp_resp=0.
REQ-023 Write with awready 3 cycles before wready -> awvalid drops after its handshake, wvalid held, single bready handshake, one rsp.
REQ-024 Read 0x3FFFF8, slave returns rdata 0xDEADBEEFCAFEF00D, rresp=2'b10 -> rsp_rdata matches, rsp_resp=2'b10.
REQ-025 TIMEOUT_CYCLES=16, rvalid withheld 40 cycles -> rsp_timeout pulse cycle 16, late r accepted in DRAIN with no rsp, cmd_ready next cycle.
REQ-026 rst during WRITE_RESP -> all valids/readies 0, cmd_ready 1 next cycle, no rsp_valid.
